// File: rtl/operand_streamer.sv
// Operand-pair buffer streamed to a MAC with valid/ready handshake.
// Define OPERAND_STREAMER_REPLAY_EN to keep the buffer after a burst for replay.
module operand_streamer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_En,
  input  logic [DATA_W-1:0]      i_Wr_X,
  input  logic [DATA_W-1:0]      i_Wr_Y,
  input  logic                   i_Clear,
  input  logic                   i_Start,
  input  logic                   i_Ready,
  output logic [DATA_W-1:0]      o_x,
  output logic [DATA_W-1:0]      o_y,
  output logic                   o_Valid,
  output logic                   o_First,
  output logic                   o_Last,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Full,
  output logic [$clog2(DEPTH):0] o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef OPERAND_STREAMER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       cnt_m1;
  logic [AW-1:0]       rd_q, rd_nxt, last_idx_q;
  logic                valid_q, first_q, last_q;
  logic [DATA_W-1:0]   x_q, y_q;
  logic                full;
  logic                do_clear, do_write, do_launch;
  logic                do_adv, do_end, do_flush;

  assign full   = (count_q == CW'(DEPTH));
  assign rd_nxt = rd_q + AW'(1);
  assign cnt_m1 = count_q - CW'(1);

  always_comb begin
    state_d   = state_q;
    do_clear  = 1'b0;
    do_write  = 1'b0;
    do_launch = 1'b0;
    do_adv    = 1'b0;
    do_end    = 1'b0;
    do_flush  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Clear) begin
          do_clear = 1'b1;
        end else begin
          do_write = i_Wr_En && !full;
          // start decision looks at the count before this cycle's write
          if (i_Start) begin
            if (count_q != '0) begin
              state_d   = STREAM;
              do_launch = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      STREAM: begin
        if (valid_q && i_Ready) begin
          if (last_q) begin
            state_d = DONE;
            do_end  = 1'b1;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        do_flush = !REPLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else if (do_clear || do_flush) begin
      count_q <= '0;
    end else if (do_write) begin
      count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_write) mem[count_q[AW-1:0]] <= {i_Wr_X, i_Wr_Y};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rd_q       <= '0;
      last_idx_q <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else if (do_launch) begin
      rd_q       <= '0;
      last_idx_q <= cnt_m1[AW-1:0];
      valid_q    <= 1'b1;
      first_q    <= 1'b1;
      last_q     <= (count_q == CW'(1));
      {x_q, y_q} <= mem[0];
    end else if (do_adv) begin
      rd_q       <= rd_nxt;
      first_q    <= 1'b0;
      last_q     <= (rd_nxt == last_idx_q);
      {x_q, y_q} <= mem[rd_nxt];
    end else if (do_end) begin
      rd_q    <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end
  end

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_Valid = valid_q;
  assign o_First = first_q;
  assign o_Last  = last_q;
  assign o_Busy  = (state_q != IDLE);
  assign o_Done  = (state_q == DONE);
  assign o_Full  = full;
  assign o_Count = count_q;

endmodule
